key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CNT, default 2000000, number of stable cycles required to accept a level change (20 ms at 100 MHz).
REQ-002 SHALL have parameter LONG_CNT, default 200000000, number of held cycles after press acceptance before a long-press pulse (2 s).
REQ-003 SHALL have port SYSCLK, input, 1 bit, 100 MHz system clock, the single clock domain.
REQ-004 SHALL have port RST_N, input, 1 bit, reset that is asynchronous and active-low.
REQ-005 SHALL have port KEY_IN, input, 1 bit, raw mechanical button, asynchronous to SYSCLK, 1 = pressed.
REQ-006 SHALL have port SEL, output, 1 bit, registered one-cycle pulse per accepted press; drives the PWM mode-step input.
REQ-007 SHALL have port KEY_LEVEL, output, 1 bit, registered debounced button level.
REQ-008 SHALL have port LONG_PRESS, output, 1 bit, registered one-cycle pulse when a press has been held LONG_CNT cycles.

Function
REQ-009 SHALL pass KEY_IN through a 2-flop synchronizer; only the second flop (key_s) feeds any logic.
REQ-010 SHALL implement FSM states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT, with a debounce counter and a hold counter each 28 bits wide.
REQ-011 In IDLE, when key_s=1 SHALL go to PRESS_WAIT and clear the debounce counter; otherwise SHALL stay in IDLE.
REQ-012 In PRESS_WAIT, key_s=0 SHALL return to IDLE with no SEL pulse (bounce rejected).
REQ-013 In PRESS_WAIT, key_s=1 and debounce counter = DEBOUNCE_CNT-1 SHALL go to PRESSED, pulse SEL for exactly one cycle, set KEY_LEVEL=1, clear the hold counter and clear the long-fired flag.
REQ-014 In PRESS_WAIT, when REQ-012 and REQ-013 do not apply, the debounce counter SHALL increment.
REQ-015 Latency SHALL be: with KEY_IN rising before SYSCLK edge 1 and held stable, SEL is high for exactly the cycle following edge DEBOUNCE_CNT+3.
REQ-016 In PRESSED with key_s=1, the hold counter SHALL increment, saturating at LONG_CNT-1.
REQ-017 In PRESSED, when the hold counter = LONG_CNT-1 and the long-fired flag is 0, LONG_PRESS SHALL pulse for one cycle and the flag SHALL set; a press SHALL never produce a second LONG_PRESS.
REQ-018 In PRESSED, key_s=0 SHALL go to RELEASE_WAIT, clear the debounce counter, and freeze the hold counter.
REQ-019 In RELEASE_WAIT, key_s=1 SHALL return to PRESSED with the hold counter and long-fired flag preserved, and with no new SEL pulse.
REQ-020 In RELEASE_WAIT, key_s=0 and debounce counter = DEBOUNCE_CNT-1 SHALL go to IDLE and set KEY_LEVEL=0; otherwise the debounce counter SHALL increment.
REQ-021 SEL and LONG_PRESS SHALL never be high in the same cycle, since LONG_CNT is at least 2.
REQ-022 SEL SHALL never be high on two consecutive cycles.
REQ-023 Exactly one SEL pulse SHALL be produced per accepted press, regardless of hold duration.
REQ-024 Values DEBOUNCE_CNT < 1 or LONG_CNT < 2 are illegal and need not be supported.

Reset
REQ-025 RST_N=0 SHALL asynchronously force state to IDLE, clear both synchronizer flops, both counters and the long-fired flag, and set SEL=0, KEY_LEVEL=0, LONG_PRESS=0.
REQ-026 Reset mid-press SHALL abort without any pulse.
REQ-027 After reset release with KEY_IN still high, the block SHALL run a full PRESS_WAIT and emit one SEL pulse.

Verification (DEBOUNCE_CNT=4, LONG_CNT=16)
REQ-028 Clean press: KEY_IN 0->1 before edge 1, held high -> SEL=1 only after edge 7, KEY_LEVEL=1 from edge 7 on.
REQ-029 Bounce: KEY_IN high for 3 cycles then low, repeated 5 times -> SEL stays 0 and KEY_LEVEL stays 0 throughout.
REQ-030 Long hold: KEY_IN held high for 40 cycles -> one SEL pulse, then one LONG_PRESS pulse exactly 16 cycles after the SEL pulse, and no further pulses.
REQ-031 Release glitch: while PRESSED, KEY_IN low for 2 cycles then high -> no SEL pulse and KEY_LEVEL stays 1.
REQ-032 Release: KEY_IN low -> KEY_LEVEL drops to 0 on edge 7 after the change.
REQ-033 Reset mid-debounce: RST_N low for 1 cycle during PRESS_WAIT -> all outputs 0 immediately; with KEY_IN still high after release -> SEL pulse 7 edges later.

Source files
------------

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchronizer, debounce FSM, and press/long-press pulse generation.
// SEL pulses once per accepted press; LONG_PRESS pulses once per press after a long hold.
module key_debounce #(
  parameter int DEBOUNCE_CNT = 2000000,
  parameter int LONG_CNT     = 200000000
) (
  input  logic SYSCLK,
  input  logic RST_N,
  input  logic KEY_IN,
  output logic SEL,
  output logic KEY_LEVEL,
  output logic LONG_PRESS
);

  // state        | meaning
  // IDLE         | debounced level low, waiting for key_s to rise
  // PRESS_WAIT   | key_s high, counting stable cycles before accepting the press
  // PRESSED      | debounced level high, hold counter running toward long press
  // RELEASE_WAIT | key_s low, counting stable cycles before accepting the release
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [27:0] DB_LAST   = 28'(DEBOUNCE_CNT - 1);
  localparam logic [27:0] LONG_LAST = 28'(LONG_CNT - 1);

  logic [1:0]  sync_q, sync_d;
  state_t      state_q, state_d;
  logic [27:0] dcnt_q, dcnt_d;
  logic [27:0] hold_q, hold_d;
  logic        fired_q, fired_d;
  logic        sel_q, sel_d;
  logic        level_q, level_d;
  logic        long_q, long_d;
  logic        key_s;

  assign key_s  = sync_q[1];
  assign sync_d = {sync_q[0], KEY_IN};

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    hold_d  = hold_q;
    fired_d = fired_q;
    level_d = level_q;
    sel_d   = 1'b0;
    long_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_s) begin
          state_d = PRESS_WAIT;
          dcnt_d  = '0;
        end
      end
      PRESS_WAIT: begin
        if (!key_s) begin
          state_d = IDLE;
        end else if (dcnt_q == DB_LAST) begin
          state_d = PRESSED;
          sel_d   = 1'b1;
          level_d = 1'b1;
          hold_d  = '0;
          fired_d = 1'b0;
        end else begin
          dcnt_d = dcnt_q + 28'd1;
        end
      end
      PRESSED: begin
        // fired flag guarantees a single long-press pulse per press, even across release glitches
        if ((hold_q == LONG_LAST) && !fired_q) begin
          long_d  = 1'b1;
          fired_d = 1'b1;
        end
        if (!key_s) begin
          state_d = RELEASE_WAIT;
          dcnt_d  = '0;
        end else if (hold_q != LONG_LAST) begin
          hold_d = hold_q + 28'd1;
        end
      end
      RELEASE_WAIT: begin
        if (key_s) begin
          state_d = PRESSED;
        end else if (dcnt_q == DB_LAST) begin
          state_d = IDLE;
          level_d = 1'b0;
        end else begin
          dcnt_d = dcnt_q + 28'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge SYSCLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q  <= '0;
      state_q <= IDLE;
      dcnt_q  <= '0;
      hold_q  <= '0;
      fired_q <= 1'b0;
      sel_q   <= 1'b0;
      level_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      hold_q  <= hold_d;
      fired_q <= fired_d;
      sel_q   <= sel_d;
      level_q <= level_d;
      long_q  <= long_d;
    end
  end

  assign SEL        = sel_q;
  assign KEY_LEVEL  = level_q;
  assign LONG_PRESS = long_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CNT=4, LONG_CNT=16.
// Edge numbers count SYSCLK rising edges after the stimulus change; outputs are sampled 1 ns after each edge.
module tb_key_debounce;

  logic clk = 1'b0;
  logic rst_n;
  logic key_in;
  logic sel;
  logic key_level;
  logic long_press;

  int n_total = 0;
  int n_bad   = 0;

  key_debounce #(
    .DEBOUNCE_CNT(4),
    .LONG_CNT(16)
  ) dut (
    .SYSCLK    (clk),
    .RST_N     (rst_n),
    .KEY_IN    (key_in),
    .SEL       (sel),
    .KEY_LEVEL (key_level),
    .LONG_PRESS(long_press)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_sel, input logic e_lvl, input logic e_long);
    check({tag, "_sel"},  sel,        e_sel);
    check({tag, "_lvl"},  key_level,  e_lvl);
    check({tag, "_long"}, long_press, e_long);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic to_negedge();
    @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    key_in = 1'b0;
    #1;
    check_outs("reset", 1'b0, 1'b0, 1'b0);
    repeat (3) to_negedge();
    rst_n = 1'b1;
    repeat (4) step();
    check_outs("idle", 1'b0, 1'b0, 1'b0);

    // clean press held 40 cycles: SEL after edge 7, LONG_PRESS 16 cycles later, nothing else
    to_negedge();
    key_in = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      step();
      check_outs($sformatf("press_e%0d", e), (e == 7), (e >= 7), (e == 23));
    end

    // release glitch of 2 cycles: level stays high, no new pulses
    to_negedge();
    key_in = 1'b0;
    step();
    check_outs("glitch_e1", 1'b0, 1'b1, 1'b0);
    to_negedge();
    step();
    check_outs("glitch_e2", 1'b0, 1'b1, 1'b0);
    to_negedge();
    key_in = 1'b1;
    for (int e = 3; e <= 24; e++) begin
      step();
      check_outs($sformatf("glitch_e%0d", e), 1'b0, 1'b1, 1'b0);
    end

    // clean release: level drops on edge 7
    to_negedge();
    key_in = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      check_outs($sformatf("release_e%0d", e), 1'b0, (e < 7), 1'b0);
    end

    // bounce: 3 high / 3 low, five times, never accepted
    for (int r = 0; r < 5; r++) begin
      to_negedge();
      key_in = 1'b1;
      for (int c = 0; c < 3; c++) begin
        step();
        check_outs($sformatf("bounce_r%0d_h%0d", r, c), 1'b0, 1'b0, 1'b0);
        if (c < 2) to_negedge();
      end
      to_negedge();
      key_in = 1'b0;
      for (int c = 0; c < 3; c++) begin
        step();
        check_outs($sformatf("bounce_r%0d_l%0d", r, c), 1'b0, 1'b0, 1'b0);
        if (c < 2) to_negedge();
      end
    end
    repeat (4) step();
    check_outs("bounce_end", 1'b0, 1'b0, 1'b0);

    // reset mid-debounce, key still high afterwards: full new debounce
    to_negedge();
    key_in = 1'b1;
    repeat (4) step();
    check_outs("pw_before_rst", 1'b0, 1'b0, 1'b0);
    to_negedge();
    rst_n = 1'b0;
    #1;
    check_outs("rst_pw", 1'b0, 1'b0, 1'b0);
    to_negedge();
    rst_n = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      check_outs($sformatf("rst_pw_e%0d", e), (e == 7), (e >= 7), 1'b0);
    end

    // reset while pressed clears the level at once; then a fresh press fires both pulses again
    to_negedge();
    rst_n = 1'b0;
    #1;
    check_outs("rst_pressed", 1'b0, 1'b0, 1'b0);
    to_negedge();
    rst_n = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      step();
      check_outs($sformatf("rst_press_e%0d", e), (e == 7), (e >= 7), (e == 23));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
